// File: rtl/vj_frame_sequencer.sv
// vj_frame_sequencer: stores UART pixel bytes into the frame buffer, kicks off
// the Viola-Jones pipeline, queues detected faces and serialises 5-byte result
// packets (plus a per-frame terminator) back to the UART transmitter.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 320
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 240
`endif

module vj_frame_sequencer #(
  parameter int unsigned IMG_W      = `LAPTOP_WIDTH,
  parameter int unsigned IMG_H      = `LAPTOP_HEIGHT,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = $clog2(IMG_W * IMG_H)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              pix_wr_en,
  output logic [ADDR_W-1:0] pix_wr_addr,
  output logic [7:0]        pix_wr_data,
  output logic              vj_start,
  input  logic              vj_done,
  input  logic              face_valid,
  input  logic [7:0]        face_r1,
  input  logic [7:0]        face_c1,
  input  logic [7:0]        face_r2,
  input  logic [7:0]        face_c2,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned       NPIX      = IMG_W * IMG_H;
  localparam int unsigned       PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RECV, RUN, DRAIN} state_t;
  typedef enum logic [1:0] {SER_IDLE, SER_ISSUE, SER_GAP, SER_FLUSH} ser_t;

  state_t            state_q, state_d;
  ser_t              ser_q, ser_d;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    fifo_cnt_q;
  logic [31:0]       sbuf_q;     // {r1, c1, r2, c2} of the packet being sent
  logic              sterm_q;    // packet being sent is the terminator
  logic [2:0]        sidx_q;     // byte index within the packet, 0..4
  logic [7:0]        cur_byte;

  logic active, fifo_empty, fifo_full, pop, push, drop;
  logic start_term, pix_take, last_pix, term_done;

  assign active     = (state_q == RUN) || (state_q == DRAIN);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  assign pop        = active && (ser_q == SER_IDLE) && !fifo_empty;
  assign push       = face_valid && (!fifo_full || pop);
  assign drop       = face_valid && fifo_full && !pop;
  assign start_term = (state_q == DRAIN) && (ser_q == SER_IDLE) && fifo_empty;
  assign pix_take   = (state_q == RECV) && rx_valid;
  assign last_pix   = pix_take && (pix_cnt_q == LAST_ADDR);
  assign term_done  = (ser_q == SER_FLUSH) && !tx_busy && sterm_q;

  assign busy     = active;
  assign tx_start = (ser_q == SER_ISSUE) && !tx_busy;
  assign tx_data  = (ser_q == SER_ISSUE) ? cur_byte : '0;

  // Packet byte order: header (1 for a face, 0 for terminator), c1, r1, c2, r2.
  always_comb begin
    cur_byte = '0;
    case (sidx_q)
      3'd0:    cur_byte = {7'b0, ~sterm_q};
      3'd1:    cur_byte = sbuf_q[23:16];
      3'd2:    cur_byte = sbuf_q[31:24];
      3'd3:    cur_byte = sbuf_q[7:0];
      3'd4:    cur_byte = sbuf_q[15:8];
      default: cur_byte = '0;
    endcase
  end

  // Next-state logic for the frame FSM and the byte serialiser.
  always_comb begin
    state_d = state_q;
    ser_d   = ser_q;
    case (state_q)
      RECV:    if (last_pix)  state_d = RUN;
      RUN:     if (vj_done)   state_d = DRAIN;
      DRAIN:   if (term_done) state_d = RECV;
      default: state_d = RECV;
    endcase
    case (ser_q)
      SER_IDLE:  if (pop || start_term) ser_d = SER_ISSUE;
      SER_ISSUE: if (!tx_busy) ser_d = SER_GAP;
      // tx_busy only rises the cycle after tx_start, so skip one cycle before re-checking it.
      SER_GAP:   ser_d = (sidx_q == 3'd4) ? SER_FLUSH : SER_ISSUE;
      SER_FLUSH: if (!tx_busy) ser_d = SER_IDLE;
      default:   ser_d = SER_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RECV;
      ser_q   <= SER_IDLE;
    end else begin
      state_q <= state_d;
      ser_q   <= ser_d;
    end
  end

  // Pixel write path; vj_start follows the write of the final address by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_cnt_q   <= '0;
      pix_wr_en   <= 1'b0;
      pix_wr_addr <= '0;
      pix_wr_data <= '0;
      vj_start    <= 1'b0;
    end else begin
      pix_wr_en <= pix_take;
      vj_start  <= pix_wr_en && (pix_wr_addr == LAST_ADDR);
      if (pix_take) begin
        pix_wr_addr <= pix_cnt_q;
        pix_wr_data <= rx_data;
        pix_cnt_q   <= last_pix ? '0 : pix_cnt_q + ADDR_W'(1);
      end
    end
  end

  // Face queue storage; a push into a full queue is legal when a pop frees the slot.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= {face_r1, face_c1, face_r2, face_c2};
  end

  // Face queue pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + (PTR_W + 1)'(1);
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - (PTR_W + 1)'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Serialiser packet buffer and byte index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sbuf_q  <= '0;
      sterm_q <= 1'b0;
      sidx_q  <= '0;
    end else if (pop) begin
      sbuf_q  <= fifo_mem[rd_ptr_q];
      sterm_q <= 1'b0;
      sidx_q  <= '0;
    end else if (start_term) begin
      sbuf_q  <= '0;
      sterm_q <= 1'b1;
      sidx_q  <= '0;
    end else if ((ser_q == SER_GAP) && (sidx_q != 3'd4)) begin
      sidx_q  <= sidx_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_vj_frame_sequencer.sv
// Self-checking bench for vj_frame_sequencer on a 4x3 frame with a 4-deep face queue.
module tb_vj_frame_sequencer;

  localparam int unsigned IMG_W      = 4;
  localparam int unsigned IMG_H      = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NPIX       = IMG_W * IMG_H;
  localparam int unsigned ADDR_W     = $clog2(NPIX);
  localparam int unsigned TX_BUSY_CYC = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              pix_wr_en;
  logic [ADDR_W-1:0] pix_wr_addr;
  logic [7:0]        pix_wr_data;
  logic              vj_start;
  logic              vj_done = 1'b0;
  logic              face_valid = 1'b0;
  logic [7:0]        face_r1 = '0, face_c1 = '0, face_r2 = '0, face_c2 = '0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              busy;
  logic              overflow;
  logic              tx_stall = 1'b0;

  vj_frame_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .pix_wr_en(pix_wr_en), .pix_wr_addr(pix_wr_addr), .pix_wr_data(pix_wr_data),
    .vj_start(vj_start), .vj_done(vj_done),
    .face_valid(face_valid), .face_r1(face_r1), .face_c1(face_c1),
    .face_r2(face_r2), .face_c2(face_c2),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // UART transmitter model: busy for TX_BUSY_CYC cycles starting the cycle after tx_start.
  int busy_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset)                busy_cnt <= 0;
    else if (tx_start)         busy_cnt <= TX_BUSY_CYC;
    else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || tx_stall;

  typedef struct {
    logic [7:0]        rx;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_data;
  } pix_vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  pix_vec_t   frame_tbl [NPIX];
  wr_t        exp_wr [$];
  logic [7:0] exp_tx [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         frames_stored = 0;
  int         vj_pulses = 0;
  logic       prev_final = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every frame-buffer write must match the next expected write.
  always @(negedge clock) begin
    if (reset && pix_wr_en) begin
      if (exp_wr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%02h, expected no write",
                 pix_wr_addr, pix_wr_data);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", 32'(pix_wr_addr), 32'(w.addr));
        check("wr_data", 32'(pix_wr_data), 32'(w.data));
      end
    end
  end

  // Transmit scoreboard: every tx_start byte must match the next expected byte.
  always @(negedge clock) begin
    if (reset && tx_start) begin
      if (exp_tx.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tx: byte 0x%02h sent, expected no byte", tx_data);
      end else begin
        logic [7:0] b;
        b = exp_tx.pop_front();
        check("tx_byte", 32'(tx_data), 32'(b));
      end
    end
  end

  // vj_start must come exactly one cycle after the write of the last address.
  always @(negedge clock) begin
    if (vj_start) begin
      vj_pulses++;
      check("vj_start_follows_last_write", 32'(prev_final), 32'd1);
    end
    prev_final = pix_wr_en && (pix_wr_addr == ADDR_W'(NPIX - 1));
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixels(input int n, input bit expect_wr, input logic [7:0] xorv);
    for (int i = 0; i < n; i++) begin
      rx_data  = frame_tbl[i].rx ^ xorv;
      rx_valid = 1'b1;
      if (expect_wr) exp_wr.push_back('{addr: frame_tbl[i].exp_addr,
                                        data: frame_tbl[i].exp_data ^ xorv});
      cycle();
    end
    rx_valid = 1'b0;
    if (expect_wr && n == int'(NPIX)) frames_stored++;
  endtask

  task automatic push_pkt(input logic [7:0] r1, input logic [7:0] c1,
                          input logic [7:0] r2, input logic [7:0] c2);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(c1);
    exp_tx.push_back(r1);
    exp_tx.push_back(c2);
    exp_tx.push_back(r2);
  endtask

  task automatic push_term();
    for (int i = 0; i < 5; i++) exp_tx.push_back(8'h00);
  endtask

  task automatic set_face(input logic [7:0] r1, input logic [7:0] c1,
                          input logic [7:0] r2, input logic [7:0] c2);
    face_r1 = r1; face_c1 = c1; face_r2 = r2; face_c2 = c2;
  endtask

  task automatic done_pulse();
    vj_done = 1'b1;
    cycle();
    vj_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!busy && exp_tx.size() == 0) break;
      cycle();
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_pix_wr_en"},   32'(pix_wr_en),   32'd0);
    check({name, "_pix_wr_addr"}, 32'(pix_wr_addr), 32'd0);
    check({name, "_vj_start"},    32'(vj_start),    32'd0);
    check({name, "_tx_start"},    32'(tx_start),    32'd0);
    check({name, "_tx_data"},     32'(tx_data),     32'd0);
    check({name, "_busy"},        32'(busy),        32'd0);
    check({name, "_overflow"},    32'(overflow),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int queued;
    for (int i = 0; i < int'(NPIX); i++)
      frame_tbl[i] = '{rx: 8'(i), exp_addr: ADDR_W'(i), exp_data: 8'(i)};

    // Reset state
    repeat (3) cycle();
    check_reset_outputs("in_reset");
    reset = 1'b1;
    cycle();
    check_reset_outputs("after_reset");

    // Frame 1: bytes 0x00..0x0B, then rx_valid during RUN is ignored
    send_pixels(NPIX, 1'b1, 8'h00);
    cycle();
    cycle();
    check("run_busy", 32'(busy), 32'd1);
    check("frame1_writes_left", 32'(exp_wr.size()), 32'd0);
    check("frame1_vj_pulses", 32'(vj_pulses), 32'(frames_stored));
    send_pixels(3, 1'b0, 8'hEE);
    cycle();

    // No faces: terminator only
    push_term();
    done_pulse();
    wait_idle("noface");

    // Frame 2: starts at addr 0 again; one face, first tx_start 2 cycles after face_valid
    send_pixels(NPIX, 1'b1, 8'h5A);
    set_face(8'd2, 8'd1, 8'd9, 8'd8);
    push_pkt(8'd2, 8'd1, 8'd9, 8'd8);
    face_valid = 1'b1;
    cycle();
    face_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("tx_start_latency", 32'(tx_start), 32'd1);
    check("tx_first_byte", 32'(tx_data), 32'h01);
    cycle();
    push_term();
    done_pulse();
    wait_idle("oneface");

    // Frame 3: face captured in the same cycle as vj_done
    send_pixels(NPIX, 1'b1, 8'hC3);
    set_face(8'h10, 8'h20, 8'h30, 8'h40);
    push_pkt(8'h10, 8'h20, 8'h30, 8'h40);
    push_term();
    face_valid = 1'b1;
    vj_done    = 1'b1;
    cycle();
    face_valid = 1'b0;
    vj_done    = 1'b0;
    wait_idle("face_with_done");

    // Frame 4: stalled transmitter, serializer holding one packet, 6-face burst
    check("overflow_before", 32'(overflow), 32'd0);
    send_pixels(NPIX, 1'b1, 8'h0F);
    tx_stall = 1'b1;
    set_face(8'h11, 8'h12, 8'h13, 8'h14);
    push_pkt(8'h11, 8'h12, 8'h13, 8'h14);
    face_valid = 1'b1;
    cycle();
    face_valid = 1'b0;
    repeat (3) cycle();
    queued = 0;
    for (int i = 0; i < 6; i++) begin
      set_face(8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i), 8'(8'h50 + i));
      if (queued < int'(FIFO_DEPTH)) begin
        push_pkt(8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i), 8'(8'h50 + i));
        queued++;
      end
      face_valid = 1'b1;
      cycle();
    end
    face_valid = 1'b0;
    cycle();
    check("overflow_set", 32'(overflow), 32'd1);
    push_term();
    done_pulse();
    tx_stall = 1'b0;
    wait_idle("overflow_burst");
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset after 5 pixels discards the frame; the next frame starts at addr 0
    send_pixels(5, 1'b1, 8'h33);
    cycle();
    reset = 1'b0;
    #2;
    check_reset_outputs("mid_frame_reset");
    cycle();
    reset = 1'b1;
    cycle();
    send_pixels(NPIX, 1'b1, 8'h77);
    push_term();
    done_pulse();
    wait_idle("after_reset_frame");

    repeat (3) cycle();
    check("final_writes_left", 32'(exp_wr.size()), 32'd0);
    check("total_vj_pulses", 32'(vj_pulses), 32'(frames_stored));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
